// File: rtl/ib_loader_if.sv
// ---------------------------------------------------------------------------
// ib_loader_if
// Bundles the ib_loader's control, byte-stream and instruction-memory write
// signals.
//   master : the load requester / byte source / memory observer
//   slave  : the loader itself
// Signals:
//   start, base_addr, num_words : load request (sampled by loader in IDLE)
//   byte_in, byte_valid         : byte stream in; byte_ready back-pressure out
//   mem_we, mem_addr, mem_wdata : instruction-memory write port
//   busy, fetch_stall, done     : status to the fetch path / requester
// ---------------------------------------------------------------------------
interface ib_loader_if #(
    parameter int unsigned AWIDTH = 6
);
    logic              start;
    logic [AWIDTH-1:0] base_addr;
    logic [AWIDTH:0]   num_words;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [AWIDTH-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              fetch_stall;
    logic              done;

    modport master (
        output start, base_addr, num_words, byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_wdata, busy, fetch_stall, done
    );

    modport slave (
        input  start, base_addr, num_words, byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_wdata, busy, fetch_stall, done
    );
endinterface

// File: rtl/ib_loader.sv
// ---------------------------------------------------------------------------
// ib_loader
// Instruction-memory loader. Packs a little-endian byte stream into 32-bit
// words and writes them to consecutive addresses (modulo 2^AWIDTH) starting
// at a programmable base. fetch_stall is held for the whole load.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : ib_loader_if.slave (request, byte stream, memory write, status)
// ---------------------------------------------------------------------------
module ib_loader #(
    parameter int unsigned AWIDTH = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    ib_loader_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    state_t            state_q,     state_d;
    logic [AWIDTH-1:0] addr_q,      addr_d;
    logic [AWIDTH:0]   remain_q,    remain_d;
    logic [1:0]        idx_q,       idx_d;
    logic [23:0]       word_q,      word_d;
    logic [AWIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    localparam logic [AWIDTH:0] REMAIN_ONE = {{AWIDTH{1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remain_q    <= '0;
            idx_q       <= '0;
            word_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remain_d    = remain_q;
        idx_d       = idx_q;
        word_d      = word_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    addr_d   = bus.base_addr;
                    remain_d = bus.num_words;
                    idx_d    = '0;
                    state_d  = (bus.num_words == '0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (bus.byte_valid) begin
                    if (idx_q == 2'd3) begin
                        // Final byte goes straight into the write register
                        // together with the three stored bytes, so the
                        // memory port is loaded on entry to WRITE and then
                        // simply holds until the next word.
                        mem_wdata_d = {bus.byte_in, word_q};
                        mem_addr_d  = addr_q;
                        state_d     = WRITE;
                    end else begin
                        word_d[8*idx_q +: 8] = bus.byte_in;
                        idx_d                = idx_q + 2'd1;
                    end
                end
            end
            WRITE: begin
                addr_d   = addr_q + 1'b1;
                remain_d = remain_q - 1'b1;
                idx_d    = '0;
                state_d  = (remain_q == REMAIN_ONE) ? DONE : COLLECT;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All status outputs decode from the state register only.
    assign bus.byte_ready  = (state_q == COLLECT);
    assign bus.mem_we      = (state_q == WRITE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.fetch_stall = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_ib_loader.sv
// ---------------------------------------------------------------------------
// tb_ib_loader
// Scoreboard bench for ib_loader: expected (address, word) pairs are queued
// as each load is requested and popped whenever the DUT pulses mem_we.
// ---------------------------------------------------------------------------
module tb_ib_loader;

    localparam int unsigned AWIDTH = 6;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_tests;
    int   n_fail;
    int   we_cnt;
    int   first_we_cyc;
    int   wr_hits [64];
    logic [37:0] sb [$];

    ib_loader_if #(.AWIDTH(AWIDTH)) bus ();

    ib_loader #(.AWIDTH(AWIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wgen(input int i, input logic [31:0] salt);
        logic [31:0] k;
        k = i;
        return (32'h12345678 ^ salt) + k * 32'h9E3779B9;
    endfunction

    // Write monitor: every mem_we pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [37:0] e;
        if (rst_n && bus.mem_we) begin
            if (we_cnt == 0) first_we_cyc = cyc;
            we_cnt++;
            wr_hits[bus.mem_addr]++;
            if (sb.size() == 0) begin
                check("spurious_we", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("mem_addr", 64'(bus.mem_addr), 64'(e[37:32]));
                check("mem_wdata", 64'(bus.mem_wdata), 64'(e[31:0]));
            end
        end
    end

    // Runs one load. exp_lat < 0 skips the start-to-done latency check.
    // restart_at >= 0 pulses a second start on that loop iteration.
    // abort_after > 0 asserts reset once that many bytes have been consumed.
    task automatic do_load(input int base, input int n, input logic [31:0] salt,
                           input bit gaps, input int restart_at,
                           input int abort_after, input int exp_lat);
        logic [7:0] bq [$];
        logic [31:0] w;
        bit   offered;
        bit   rdy;
        bit   seen_done;
        int   start_cyc;
        int   consumed;
        int   k;
        for (int i = 0; i < n; i++) begin
            w = wgen(i, salt);
            sb.push_back({6'((base + i) % 64), w});
            bq.push_back(w[7:0]);
            bq.push_back(w[15:8]);
            bq.push_back(w[23:16]);
            bq.push_back(w[31:24]);
        end
        for (int a = 0; a < 64; a++) wr_hits[a] = 0;
        @(negedge clk);
        we_cnt         = 0;
        first_we_cyc   = -1;
        bus.start      = 1'b1;
        bus.base_addr  = 6'(base);
        bus.num_words  = 7'(n);
        bus.byte_valid = 1'b0;
        start_cyc      = cyc;
        offered        = 1'b0;
        rdy            = 1'b0;
        seen_done      = 1'b0;
        consumed       = 0;
        k              = 0;
        while (k < 20 * n + 50) begin
            @(negedge clk);
            bus.start = (k == restart_at);
            if (k == restart_at) bus.num_words = 7'd9;
            if (k == 0) check("busy_on", 64'({bus.busy, bus.fetch_stall}), 64'd3);
            if (offered && rdy) begin
                void'(bq.pop_front());
                consumed++;
            end
            if (abort_after > 0 && consumed == abort_after) begin
                rst_n = 1'b0;
                #1;
                check("rst_outs", {bus.byte_ready, bus.mem_we, bus.busy, bus.fetch_stall,
                                   bus.done, bus.mem_addr, bus.mem_wdata}, 64'd0);
                sb.delete();
                bus.byte_valid = 1'b0;
                bus.start      = 1'b0;
                return;
            end
            if (bus.done) begin
                seen_done = 1'b1;
                break;
            end
            rdy            = bus.byte_ready;
            bus.byte_valid = (bq.size() > 0) && (!gaps || (k % 3 == 0));
            bus.byte_in    = (bq.size() > 0) ? bq[0] : 8'h00;
            offered        = bus.byte_valid;
            k++;
        end
        bus.byte_valid = 1'b0;
        bus.start      = 1'b0;
        check("done_seen", 64'(seen_done), 64'd1);
        check("we_count", 64'(we_cnt), 64'(n));
        check("sb_drained", 64'(sb.size()), 64'd0);
        if (exp_lat >= 0) check("done_latency", 64'(cyc - start_cyc), 64'(exp_lat));
        if (n == 1 && exp_lat >= 0)
            check("we_latency", 64'(first_we_cyc - start_cyc), 64'd5);
        @(negedge clk);
        check("idle_after", 64'({bus.busy, bus.fetch_stall, bus.done, bus.byte_ready}), 64'd0);
        sb.delete();
    endtask

    initial begin
        int once;
        n_tests        = 0;
        n_fail         = 0;
        cyc            = 0;
        we_cnt         = 0;
        bus.start      = 1'b0;
        bus.base_addr  = '0;
        bus.num_words  = '0;
        bus.byte_in    = '0;
        bus.byte_valid = 1'b0;
        rst_n          = 1'b0;
        #12;
        check("reset_outs", {bus.byte_ready, bus.mem_we, bus.busy, bus.fetch_stall,
                             bus.done, bus.mem_addr, bus.mem_wdata}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single word 0x12345678 at address 5.
        do_load(5, 1, 32'h0, 1'b0, -1, 0, 6);
        // Wrap from the top address.
        do_load(63, 2, 32'hA5A5_0F0F, 1'b0, -1, 0, 11);
        // Same three words with and without byte gaps.
        do_load(30, 3, 32'hC0DE_1234, 1'b0, -1, 0, 16);
        do_load(30, 3, 32'hC0DE_1234, 1'b1, -1, 0, -1);
        // Zero length.
        do_load(7, 0, 32'h0, 1'b0, -1, 0, 1);
        // Start during a load is ignored.
        do_load(40, 2, 32'h5555_AAAA, 1'b0, 3, 0, 11);

        // Reset after two bytes of the second word.
        do_load(20, 3, 32'h0BAD_F00D, 1'b0, -1, 6, -1);
        repeat (3) @(negedge clk);
        check("rst_we_count", 64'(we_cnt), 64'd1);
        check("rst_held_idle", 64'({bus.busy, bus.mem_we, bus.mem_addr}), 64'd0);
        rst_n = 1'b1;
        do_load(0, 2, 32'h1357_9BDF, 1'b0, -1, 0, 11);

        // Full memory from base 10.
        do_load(10, 64, 32'hFEED_BEEF, 1'b0, -1, 0, 321);
        once = 0;
        for (int a = 0; a < 64; a++) if (wr_hits[a] == 1) once++;
        check("full_cover", 64'(once), 64'd64);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ib_loader.md
# ib_loader

Instruction-memory loader for the 32-bit processor's instruction block: the write-side counterpart to the fetch-side address incrementer. It accepts a byte stream over a valid/ready handshake, packs four bytes little-endian into a 32-bit instruction word, and writes words to consecutive instruction-memory addresses from a programmable base. While loading it asserts a stall so the fetch path does not read partially written memory.

## Interface

Parameters:
- AWIDTH, 6, instruction-memory address width; addresses wrap modulo 2^AWIDTH.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- base_addr  input  AWIDTH  first write address; captured on accepted start.
- num_words  input  AWIDTH+1  words to load (0 to 2^AWIDTH); captured on accepted start.
- byte_in  input  8  stream data.
- byte_valid  input  1  byte_in holds a valid byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction-memory write enable, one-cycle pulse per word.
- mem_addr  output  AWIDTH  write address.
- mem_wdata  output  32  write data.
- busy  output  1  high from accepted start until return to IDLE.
- fetch_stall  output  1  equals busy; holds the fetch path.
- done  output  1  one-cycle pulse when the load completes.

## Operation

- States: IDLE, COLLECT, WRITE, DONE.
- IDLE: byte_ready=0. If start=1, capture base_addr into the address counter and num_words into the remaining counter, clear the byte index, and go to COLLECT; if num_words=0, go directly to DONE.
- COLLECT: byte_ready=1. A byte transfers when byte_valid and byte_ready are both high. Byte index k (0..3) goes to bits [8k+7:8k] of the word register; the first byte lands in [7:0]. After the 4th transfer, go to WRITE. byte_valid low causes a wait with no state change.
- WRITE: byte_ready=0; mem_we=1, mem_addr=address counter, mem_wdata=packed word. On exit, increment the address counter by 1 (wraps from 2^AWIDTH-1 to 0), decrement remaining, and clear the byte index. Go to DONE if remaining was 1, else COLLECT.
- DONE: done=1, busy=1, byte_ready=0; the next state is IDLE.
- start outside IDLE is ignored; it is not queued.
- Bytes offered while byte_ready=0 are not consumed; the source holds them.
- mem_addr and mem_wdata hold their last values when mem_we=0.

## Timing

- Reset (rst_n low, asynchronous): state=IDLE; byte_ready, mem_we, busy, fetch_stall, done=0; mem_addr, mem_wdata, word register, and counters=0. Effective immediately, including mid-load. A partially packed word is discarded and never written.
- busy and fetch_stall go high the cycle after start is accepted and go low the cycle after DONE.
- With byte_valid held high, each word takes 5 cycles: 4 COLLECT and 1 WRITE. N words take 5N+1 cycles from start to the done pulse, counting the DONE cycle.
- num_words=0: start, then DONE for 1 cycle, then IDLE; mem_we is never asserted.
- num_words=2^AWIDTH: every address is written once, and the counter wraps back to base_addr.
- All outputs are registered or decoded from state only; there are no combinational paths from byte_valid to byte_ready.

## Test plan

- Single word: base_addr=5, num_words=1, bytes 0x78,0x56,0x34,0x12 streamed back-to-back -> one mem_we pulse with mem_addr=5 and mem_wdata=0x12345678 on the 5th cycle after start, followed by the done pulse on the next cycle.
- Wrap: AWIDTH=6, base_addr=63, num_words=2 -> writes at addresses 63 then 0, with the correct words.
- Backpressure/gaps: byte_valid toggled 1,0,0,1,… across 3 words -> identical mem_wdata sequence to the gap-free run, and exactly 3 mem_we pulses.
- Zero length and ignored start: num_words=0 -> done pulses with no mem_we; a second start asserted mid-load is ignored and the load finishes with its original count.
- Reset mid-word: rst_n pulled low after 2 bytes of word 2 -> all outputs 0 immediately, no write for word 2, and a later fresh load from base 0 behaves normally.
- Full memory: base_addr=10, num_words=64 -> 64 writes covering every address exactly once; done arrives 321 cycles after start.
